// File: rtl/psk_tx_modulator.sv
// BPSK/QPSK transmit modulator: symbol phase offsets on a free-running carrier.
// Define PSK_TX_UNDERFLOW_CNT_EN to build the saturating underflow counter.
module psk_tx_modulator #(
   parameter int          PHASE_WIDTH     = 16,
   parameter logic [15:0] FREE_FREQ       = 16'h4000,
   parameter int          SAMPLES_PER_SYM = 16,
   parameter int          O_WIDTH         = 12
) (
   input  logic               clk_16M384,
   input  logic               rst_n_16M384,
   input  logic               en,
   input  logic               is_bpsk,
   input  logic [1:0]         s_sym_tdata,
   input  logic               s_sym_tvalid,
   output logic               s_sym_tready,
   output logic [O_WIDTH-1:0] tx_sample,
   output logic               tx_valid,
   output logic               sym_start,
   output logic [7:0]         underflow_cnt
);

   localparam int            PW   = PHASE_WIDTH;
   localparam int            CW   = $clog2(SAMPLES_PER_SYM);
   localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_SYM - 1);

   logic [PW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    ofs_q, ofs_d;
   logic          act_q, act_d;
   logic [2:0]    sym_ofs;
   logic          boundary;

   logic [5:0]         ph1_q;
   logic               act1_q, first1_q, vld1_q;
   logic [O_WIDTH-1:0] sample_d;

   assign boundary     = (cnt_q == LAST);
   assign s_sym_tready = en && boundary;

   // Offsets are multiples of 16'h2000; only bits [15:13] are kept.
   always_comb begin
      sym_ofs = 3'b000;
      unique case (1'b1)
         is_bpsk: sym_ofs = {s_sym_tdata[0], 2'b00};
         default: sym_ofs = {s_sym_tdata[1], ^s_sym_tdata, 1'b1};
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ofs_d = ofs_q;
      act_d = act_q;
      if (en) begin
         acc_d = acc_q + FREE_FREQ;
         cnt_d = boundary ? '0 : cnt_q + 1'b1;
         if (boundary) begin
            act_d = s_sym_tvalid;
            if (s_sym_tvalid) ofs_d = sym_ofs;
         end
      end
   end

   always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
      if (!rst_n_16M384) begin
         acc_q <= '0;
         cnt_q <= '0;
         ofs_q <= '0;
         act_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ofs_q <= ofs_d;
         act_q <= act_d;
      end
   end

   function automatic logic [O_WIDTH-1:0] qwave(input logic [3:0] k);
      logic [10:0] t;
      t = '0;
      case (k)
         4'd0:  t = 11'd100;
         4'd1:  t = 11'd300;
         4'd2:  t = 11'd497;
         4'd3:  t = 11'd690;
         4'd4:  t = 11'd875;
         4'd5:  t = 11'd1052;
         4'd6:  t = 11'd1219;
         4'd7:  t = 11'd1375;
         4'd8:  t = 11'd1517;
         4'd9:  t = 11'd1644;
         4'd10: t = 11'd1756;
         4'd11: t = 11'd1850;
         4'd12: t = 11'd1927;
         4'd13: t = 11'd1986;
         4'd14: t = 11'd2025;
         4'd15: t = 11'd2045;
      endcase
      return O_WIDTH'(t);
   endfunction

   always_comb begin
      logic [O_WIDTH-1:0] mag;
      mag      = qwave(ph1_q[4] ? ~ph1_q[3:0] : ph1_q[3:0]);
      sample_d = '0;
      if (act1_q) sample_d = ph1_q[5] ? -mag : mag;
   end

   // Low accumulator bits never reach the LUT index, so only [15:10] is staged.
   always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
      if (!rst_n_16M384) begin
         ph1_q     <= '0;
         act1_q    <= 1'b0;
         first1_q  <= 1'b0;
         vld1_q    <= 1'b0;
         tx_sample <= '0;
         sym_start <= 1'b0;
         tx_valid  <= 1'b0;
      end else begin
         ph1_q     <= acc_q[PW-1:PW-6] + {ofs_q, 3'b000};
         act1_q    <= act_q;
         first1_q  <= en && (cnt_q == '0) && act_q;
         vld1_q    <= en;
         tx_sample <= sample_d;
         sym_start <= first1_q;
         tx_valid  <= vld1_q;
      end
   end

`ifdef PSK_TX_UNDERFLOW_CNT_EN
   logic [7:0] uf_q;

   always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
      if (!rst_n_16M384) begin
         uf_q <= '0;
      end else if (s_sym_tready && !s_sym_tvalid && uf_q != 8'hFF) begin
         uf_q <= uf_q + 8'd1;
      end
   end

   assign underflow_cnt = uf_q;
`else
   assign underflow_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_psk_tx_modulator.sv
// Bench for psk_tx_modulator: per-sample reference model with random stimulus.
// Expected underflow counts follow PSK_TX_UNDERFLOW_CNT_EN.
module tb_psk_tx_modulator;

   localparam int SPS  = 16;
   localparam int FREE = 'h4000;

   logic        clk = 1'b0;
   logic        rst_n, en, is_bpsk, tvalid;
   logic [1:0]  tdata;
   logic        tready, tx_valid, sym_start;
   logic [11:0] tx_sample;
   logic [7:0]  uf_cnt;

   psk_tx_modulator dut (
      .clk_16M384   (clk),
      .rst_n_16M384 (rst_n),
      .en           (en),
      .is_bpsk      (is_bpsk),
      .s_sym_tdata  (tdata),
      .s_sym_tvalid (tvalid),
      .s_sym_tready (tready),
      .tx_sample    (tx_sample),
      .tx_valid     (tx_valid),
      .sym_start    (sym_start),
      .underflow_cnt(uf_cnt)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [11:0] s;
      logic        f;
      int          idx;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   exp_t expq[$];
   int   n, m_ofs, m_uf;
   bit   m_act, en_prev;
   logic [11:0] last4 [4];
   logic [11:0] first_by_slot [int];
   int   zrun, zmax;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sine at the centre of the 64-bin phase cell holding ph.
   function automatic logic [11:0] ref_sin(input int ph);
      real v;
      int  r;
      v = 2047.0 * $sin((2.0 * (ph >> 10) + 1.0) * 3.14159265358979 / 64.0);
      r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      return 12'(r);
   endfunction

   function automatic int sym_phase(input bit bpsk, input logic [1:0] d);
      if (bpsk) return d[0] ? 'h8000 : 'h0000;
      case (d)
         2'b00:   return 'h2000;
         2'b01:   return 'h6000;
         2'b11:   return 'hA000;
         default: return 'hE000;
      endcase
   endfunction

   function automatic int uf_exp(input int v);
`ifdef PSK_TX_UNDERFLOW_CNT_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic model_reset();
      n       = 0;
      m_ofs   = 0;
      m_uf    = 0;
      m_act   = 1'b0;
      en_prev = 1'b0;
      expq.delete();
      first_by_slot.delete();
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      chk("tready", tready, en && (n % SPS == SPS - 1));
      @(posedge clk);
      if (en) begin
         e.s   = m_act ? ref_sin((n * FREE + m_ofs) & 'hFFFF) : 12'd0;
         e.f   = m_act && (n % SPS == 0);
         e.idx = n;
         expq.push_back(e);
         if (n % SPS == SPS - 1) begin
            if (tvalid) begin
               m_ofs = sym_phase(is_bpsk, tdata);
               m_act = 1'b1;
            end else begin
               m_act = 1'b0;
               if (m_uf < 255) m_uf++;
            end
         end
         n++;
      end
      #1;
      chk("tx_valid", tx_valid, en_prev);
      en_prev = en;
      chk("underflow_cnt", uf_cnt, uf_exp(m_uf));
      if (tx_valid === 1'b1) begin
         chk("pending", expq.size() != 0, 1'b1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("tx_sample", tx_sample, e.s);
            chk("sym_start", sym_start, e.f);
            last4[e.idx % 4] = tx_sample;
            if (sym_start) first_by_slot[e.idx / SPS] = tx_sample;
            if (tx_sample == 12'd0) zrun++;
            else begin
               if (zrun > zmax) zmax = zrun;
               zrun = 0;
            end
         end
      end else begin
         chk("sym_start_idle", sym_start, 1'b0);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_sample"}, tx_sample, 12'd0);
      chk({tag, "_valid"}, tx_valid, 1'b0);
      chk({tag, "_start"}, sym_start, 1'b0);
      chk({tag, "_tready"}, tready, 1'b0);
      chk({tag, "_uf"}, uf_cnt, 8'd0);
   endtask

   logic [11:0] b0 [4];
   logic [11:0] b1 [4];
   logic [11:0] qf [4];
   logic [1:0]  qs [4];

   initial begin
      b0 = '{12'h064, 12'h7FD, 12'hF9C, 12'h803};
      b1 = '{12'hF9C, 12'h803, 12'h064, 12'h7FD};
      qf = '{12'h5ED, 12'h55F, 12'hA13, 12'hAA1};
      qs = '{2'b00, 2'b01, 2'b11, 2'b10};
      rst_n = 1'b0; en = 1'b0; is_bpsk = 1'b0; tvalid = 1'b0; tdata = 2'b00;
      zrun = 0; zmax = 0;
      model_reset();

      repeat (3) @(posedge clk);
      #1 check_idle_outputs("reset");
      rst_n = 1'b1;
      en    = 1'b1;

      // Idle stream: gaps only, tready on samples 15, 31, 47.
      repeat (48) tick();
      chk("idle_uf", uf_cnt, uf_exp(3));

      is_bpsk = 1'b1; tvalid = 1'b1; tdata = 2'b00;
      repeat (48) tick();
      for (int i = 0; i < 4; i++) chk("bpsk0_seq", last4[i], b0[i]);

      tdata = 2'b01;
      repeat (48) tick();
      for (int i = 0; i < 4; i++) chk("bpsk1_seq", last4[i], b1[i]);

      // QPSK sweep; data off the boundary is noise and must be ignored.
      is_bpsk = 1'b0;
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < SPS; i++) begin
            tdata  = (i == SPS - 1) ? qs[s] : 2'($urandom);
            tvalid = (i == SPS - 1) ? 1'b1 : 1'($urandom);
            tick();
         end
      end

      tvalid = 1'b1; tdata = 2'b11;
      repeat (16) tick();
      for (int s = 0; s < 4; s++) begin
         chk("qpsk_first_seen", first_by_slot.exists(10 + s), 1'b1);
         chk("qpsk_first", first_by_slot[10 + s], qf[s]);
      end

      zrun = 0; zmax = 0;
      tvalid = 1'b0;
      repeat (16) tick();
      tvalid = 1'b1;
      repeat (32) tick();
      chk("gap_zero_run", zmax, 16);
      chk("gap_uf", uf_cnt, uf_exp(4));

      repeat (5) tick();
      en = 1'b0;
      repeat (2) tick();
      chk("pause_valid_low", tx_valid, 1'b0);
      repeat (3) tick();
      en = 1'b1;
      repeat (27) tick();

      for (int i = 0; i < 640; i++) begin
         en      = ($urandom_range(0, 9) != 0);
         tvalid  = ($urandom_range(0, 3) != 0);
         tdata   = 2'($urandom);
         is_bpsk = 1'($urandom);
         tick();
      end

      en = 1'b1; tvalid = 1'b0;
      repeat (300 * SPS) tick();
      chk("uf_saturate", uf_cnt, uf_exp(255));

      tvalid = 1'b1; is_bpsk = 1'b0; tdata = 2'b01;
      repeat (24) tick();
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("async_rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      repeat (40) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/psk_tx_modulator.md
Name: psk_tx_modulator

Overview:
- Transmit-side counterpart of the receive carrier NCO. Takes BPSK/QPSK symbols over a ready/valid stream and generates a real passband carrier.
- Each symbol is applied as a phase offset onto a free-running phase accumulator. The output is a 12-bit signed sine sample every clk_16M384 cycle, which feeds the TX DAC path.
- Carrier frequency and symbol length are fixed by parameters. There is no DDS IP; the sine comes from an internal quarter-wave LUT.

Parameters:
- PHASE_WIDTH, 16, phase accumulator width. Only 16 is supported.
- FREE_FREQ, 16'h4000, carrier phase increment per clock (fs/4 = 4.096 MHz).
- SAMPLES_PER_SYM, 16, clocks per symbol. Must be ≥2.
- O_WIDTH, 12, output sample width, two's complement.

Ports:
- clk_16M384  in  1  system clock, 16.384 MHz.
- rst_n_16M384  in  1  asynchronous, active-low reset.
- en  in  1  run enable. When low, the block freezes.
- is_bpsk  in  1  1 = BPSK (uses s_sym_tdata[0]), 0 = QPSK. Sampled only at a symbol boundary.
- s_sym_tdata  in  2  symbol bits.
- s_sym_tvalid  in  1  symbol available.
- s_sym_tready  out  1  symbol accepted at this boundary.
- tx_sample  out  O_WIDTH  modulated carrier sample.
- tx_valid  out  1  tx_sample is valid.
- sym_start  out  1  tx_sample is the first sample of a newly accepted symbol.
- underflow_cnt  out  8  count of symbol boundaries at which no symbol was available.

Behaviour:
- Reset (async assert, sync release): all of the following are 0.
  - Outputs: tx_sample, tx_valid, sym_start, s_sym_tready, underflow_cnt.
  - Internal state: acc, sym_cnt, phase offset, active.
- Accumulator:
  - When en=1: acc <= acc + FREE_FREQ, wrapping mod 2^16.
  - sym_cnt counts 0..SAMPLES_PER_SYM-1 and wraps to 0.
  - When en=0: acc and sym_cnt hold.
- Handshake:
  - s_sym_tready = en && (sym_cnt == SAMPLES_PER_SYM-1). It is combinational, high for exactly 1 cycle per symbol period.
  - Transfer occurs when s_sym_tready && s_sym_tvalid. The offset and is_bpsk are latched, and active <= 1.
  - At a boundary with tvalid=0:
    - active <= 0; the next symbol period is a gap with zero output.
    - underflow_cnt increments, saturating at 255 (under the macro below).
  - tvalid outside a boundary is ignored. Data must be held by the source.
- Symbol-to-phase mapping:
  - BPSK: bit0 = 0 gives 16'h0000; bit0 = 1 gives 16'h8000.
  - QPSK (Gray): 00 → 16'h2000, 01 → 16'h6000, 11 → 16'hA000, 10 → 16'hE000.
- Pipeline stage 1 (register): phase <= acc + offset (mod 2^16); act1 <= active; first1 <= (sym_cnt==0 && a symbol was just loaded).
- Pipeline stage 2 (register):
  - q = phase[15:14], k = phase[13:10].
  - Value by quadrant: q0 → T[k]; q1 → T[15-k]; q2 → -T[k]; q3 → -T[15-k].
  - tx_sample = that value if act1, else 0.
  - sym_start <= first1.
- LUT: T[k] = round(2047*sin((2k+1)π/64)), k = 0..15. Fixed endpoints T[0]=100, T[15]=2045. No zero entries; symmetric about quadrants.
- Latency:
  - acc value to tx_sample: 2 clocks.
  - An accepted symbol affects the samples starting 3 clocks after its handshake cycle.
  - tx_valid equals en delayed by 2 clocks.
- Phase continuity: acc is never reset by symbols or gaps, only by reset. Phase jumps occur only at symbol boundaries.
- Mode change: is_bpsk is sampled only with the accepted symbol, so a mid-symbol toggle has no effect.
- en toggle mid-symbol: the symbol resumes where it stopped. The pipeline drains and tx_valid goes low 2 cycles after en falls.
- Reset mid-symbol: output goes to 0 immediately; the partial symbol is lost; no handshake is pending after release.

Optional Feature:
- PSK_TX_UNDERFLOW_CNT_EN defined: underflow_cnt is an 8-bit saturating counter, cleared only by reset.
- Not defined: underflow_cnt is tied to 8'd0 and no counter logic is generated. Gap behaviour is unchanged.

Test Plan:
- Reset → all outputs 0. After release with en=1 and no symbols: tx_valid=1 two cycles later, tx_sample=0, s_sym_tready pulses on cycles 15, 31, …; with macro, underflow_cnt=1, 2, ….
- BPSK bit 0 stream, FREE_FREQ=4000h → tx_sample repeats 100, 2045, -100, -2045. Bit 1 → the same sequence negated (-100, -2045, 100, 2045). sym_start is high on the first sample of each symbol.
- QPSK sweep 00/01/11/10 → per-symbol first-sample phase shifts of 2000h/6000h/A000h/E000h, checked against a reference model. tdata presented while ready=0 is not consumed.
- tvalid dropped for one period mid-stream → exactly SAMPLES_PER_SYM zero samples, then resumes with the carrier phase continuous. With macro, underflow_cnt increments by 1; without macro, it stays 0.
- en low for 5 cycles mid-symbol → acc frozen, tx_valid low after 2 cycles, symbol completes with the correct remaining count. Force 300 underflows → counter saturates at 255.
- Assert rst_n_16M384 mid-symbol asynchronously → outputs 0 in the same cycle. Toggle is_bpsk mid-symbol → no change until the next boundary.
